// File: rtl/mult8x8_ctrl_pkg.sv
// Shared codes for the 8x8 multiplier sequencer and its datapath:
// state encodings, shift codes and nibble-select codes.
package mult8x8_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'b000,
        S_LSB  = 3'b001,
        S_MID  = 3'b010,
        S_MSB  = 3'b011,
        S_DONE = 3'b100,
        S_ERR  = 3'b101
    } state_t;

    localparam logic [1:0] SHIFT_0 = 2'b00;
    localparam logic [1:0] SHIFT_4 = 2'b01;
    localparam logic [1:0] SHIFT_8 = 2'b10;

    // [1] picks the dataa nibble, [0] the datab nibble
    localparam logic [1:0] SEL_LL = 2'b00;
    localparam logic [1:0] SEL_LH = 2'b01;
    localparam logic [1:0] SEL_HL = 2'b10;
    localparam logic [1:0] SEL_HH = 2'b11;

endpackage

// File: rtl/mult8x8_ctrl_counter2.sv
// 2-bit counter with synchronous clear (priority) and enable,
// asynchronous active-low reset.
module mult8x8_ctrl_counter2 (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clr,
    input  logic       en,
    output logic [1:0] count
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= 2'd0;
        end else if (clr) begin
            count <= 2'd0;
        end else if (en) begin
            count <= count + 2'd1;
        end
    end

endmodule

// File: rtl/mult8x8_ctrl.sv
// Sequencer for the 8x8 multiplier: walks the four 4x4 partial
// products and drives mux selects, shift, accumulator control.
module mult8x8_ctrl
    import mult8x8_ctrl_pkg::*;
#(
    parameter bit ERR_STICKY = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    output logic [1:0] input_sel,
    output logic [1:0] shift_sel,
    output logic       clk_ena,
    output logic       sclr_n,
    output logic       done_flag,
    output logic [2:0] state_out
);

    state_t     state;
    state_t     state_nxt;
    logic [1:0] count;
    logic       busy;
    logic       at_rest;

    assign busy    = (state == S_LSB) || (state == S_MID) ||
                     (state == S_MSB);
    assign at_rest = (state == S_IDLE) || (state == S_ERR) ||
                     (state == S_DONE);

    mult8x8_ctrl_counter2 u_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (!busy),
        .en      (busy),
        .count   (count)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = S_IDLE;
        case (state)
            S_IDLE: state_nxt = start ? S_LSB : S_IDLE;
            S_LSB: begin
                if (!start && count == 2'd0) state_nxt = S_MID;
                else                         state_nxt = S_ERR;
            end
            S_MID: begin
                if (!start && count == 2'd1)      state_nxt = S_MID;
                else if (!start && count == 2'd2) state_nxt = S_MSB;
                else                              state_nxt = S_ERR;
            end
            S_MSB: begin
                if (!start && count == 2'd3) state_nxt = S_DONE;
                else                         state_nxt = S_ERR;
            end
            S_DONE: state_nxt = start ? S_ERR : S_IDLE;
            S_ERR: begin
                if (start)           state_nxt = S_LSB;
                else if (ERR_STICKY) state_nxt = S_ERR;
                else                 state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        input_sel = SEL_LL;
        shift_sel = SHIFT_0;
        clk_ena   = 1'b0;
        case (state)
            S_LSB: begin
                if (count == 2'd0) begin
                    input_sel = SEL_LL;
                    shift_sel = SHIFT_0;
                    clk_ena   = 1'b1;
                end
            end
            S_MID: begin
                if (count == 2'd1) begin
                    input_sel = SEL_LH;
                    shift_sel = SHIFT_4;
                    clk_ena   = 1'b1;
                end else if (count == 2'd2) begin
                    input_sel = SEL_HL;
                    shift_sel = SHIFT_4;
                    clk_ena   = 1'b1;
                end
            end
            S_MSB: begin
                if (count == 2'd3) begin
                    input_sel = SEL_HH;
                    shift_sel = SHIFT_8;
                    clk_ena   = 1'b1;
                end
            end
            default: begin
                input_sel = SEL_LL;
                shift_sel = SHIFT_0;
                clk_ena   = 1'b0;
            end
        endcase
    end

    // Clear lands on the same edge that enters LSB.
    assign sclr_n    = !(at_rest && start);
    assign done_flag = (state == S_DONE);
    assign state_out = state;

endmodule
